// File: rtl/ppe_tx_arb_pkg.sv
// Shared types and default sizing for the ppe transmit-path slave arbiter.
// arb_state_e : arbiter FSM states
// *_DEF       : default parameter values for tx_slv_arbiter
// idw_of      : grant-index width for a given requester count (never below 1)
package ppe_tx_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DW_DEF        = 32;
    localparam int STALL_MAX_DEF = 1024;

    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of req, starting at position ptr and wrapping
// past N-1 back to 0. The search rotates req so ptr lands at bit 0,
// priority-encodes the lowest set bit, then adds ptr back modulo N.
// Ports:
//   req   : request vector
//   ptr   : highest-priority position (expected < N)
//   found : at least one request set
//   idx   : index of the chosen request (0 when found=0)
module tx_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] N_V = (IW+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) off = IW'(j);
        end
        found = |rot;
        sum   = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_V) sum = sum - N_V;
        idx = found ? sum[IW-1:0] : '0;
    end

endmodule

// File: rtl/tx_slv_arbiter.sv
// Packet-level round-robin arbiter sharing one tx slave port among NUM_REQ
// requesters. A grant is held from the first beat through the beat carrying
// last, so packets never interleave. In BUSY the owner is muxed straight
// through to the slave with no register stage. A watchdog flags a slave
// that withholds async_rdy for STALL_MAX consecutive BUSY cycles.
//
// state | meaning
// IDLE  | no owner; arbitrate among current req_valid, register the pick
// BUSY  | gnt_id owns the port until its last beat handshakes
//
// Ports:
//   clk, rst             : clock, async active-high reset
//   req_valid/data/last  : per-requester beat (requester i at [i*DW +: DW])
//   req_ready            : per-requester beat accepted
//   async_en/tx_data/tx_last, async_rdy : slave-side beat handshake
//   gnt_id, busy         : current owner, packet in progress
//   stall_err, stall_clr : sticky watchdog flag and its clear
module tx_slv_arbiter
    import ppe_tx_arb_pkg::*;
#(
    parameter int  NUM_REQ   = NUM_REQ_DEF,
    parameter int  DW        = DW_DEF,
    parameter int  STALL_MAX = STALL_MAX_DEF,
    localparam int IDW       = idw_of(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  async_en,
    output logic [DW-1:0]         tx_data,
    output logic                  tx_last,
    input  logic                  async_rdy,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy,
    output logic                  stall_err,
    input  logic                  stall_clr
);

    // Counter only has to reach STALL_MAX-1 before it saturates.
    localparam int             SCW      = $clog2(STALL_MAX);
    localparam logic [SCW-1:0] STALL_TC = SCW'(STALL_MAX - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

    arb_state_e     state, state_nxt;
    logic [IDW-1:0] rr_ptr, rr_ptr_nxt, gnt_nxt;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic [SCW-1:0] stall_cnt;
    logic           hs;

    tx_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt_id <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            gnt_id <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        gnt_nxt    = gnt_id;
        async_en   = 1'b0;
        tx_data    = '0;
        tx_last    = 1'b0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = BUSY;
                    gnt_nxt   = pick_idx;
                end
            end
            BUSY: begin
                async_en          = req_valid[gnt_id];
                tx_data           = req_data[gnt_id*DW +: DW];
                tx_last           = req_last[gnt_id];
                req_ready[gnt_id] = async_rdy;
                if (async_en && async_rdy && tx_last) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == BUSY);
    assign hs   = async_en & async_rdy;

    // Watchdog: counts consecutive BUSY cycles without a handshake; the
    // packet keeps running after the flag sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (!busy || hs) begin
            stall_cnt <= '0;
        end else if (stall_cnt == STALL_TC) begin
            stall_err <= 1'b1;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_slv_arbiter.sv
// Bench for tx_slv_arbiter: a packet-level model runs beside the DUT and is
// compared on every falling edge; directed scenarios add literal checks.
module tb_tx_slv_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int SM = 8;

    logic               clk, rst;
    logic [NR-1:0]      req_valid, req_last, req_ready;
    logic [NR*DW-1:0]   req_data;
    logic               async_en, tx_last, async_rdy, busy, stall_err, stall_clr;
    logic [DW-1:0]      tx_data;
    logic [1:0]         gnt_id;

    int errors = 0;
    int checks = 0;

    tx_slv_arbiter #(.NUM_REQ(NR), .DW(DW), .STALL_MAX(SM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .async_en  (async_en),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .async_rdy (async_rdy),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .stall_err (stall_err),
        .stall_clr (stall_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // owner = requester holding the port (-1: none); ptr = next priority start;
    // run = consecutive BUSY cycles without a handshake.
    int m_owner, m_ptr, m_run, m_j;
    bit m_err;

    initial begin
        logic [NR-1:0] e_rdy;
        logic [DW-1:0] e_data;
        logic          e_en, e_last, m_hs;
        m_owner = -1; m_ptr = 0; m_run = 0; m_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_en", async_en, 0);
                chk("rst_ready", req_ready, 0);
                chk("rst_data", tx_data, 0);
                chk("rst_last", tx_last, 0);
                chk("rst_err", stall_err, 0);
                chk("rst_gnt", gnt_id, 0);
                m_owner = -1; m_ptr = 0; m_run = 0; m_err = 0;
            end else begin
                e_en   = (m_owner >= 0) ? req_valid[m_owner] : 1'b0;
                e_last = (m_owner >= 0) ? req_last[m_owner] : 1'b0;
                e_data = (m_owner >= 0) ? req_data[m_owner*DW +: DW] : '0;
                e_rdy  = '0;
                if (m_owner >= 0) e_rdy[m_owner] = async_rdy;
                chk("busy", busy, m_owner >= 0);
                chk("async_en", async_en, e_en);
                chk("tx_data", tx_data, e_data);
                chk("tx_last", tx_last, e_last);
                chk("req_ready", req_ready, e_rdy);
                chk("stall_err", stall_err, m_err);
                if (m_owner >= 0) chk("gnt_id", gnt_id, m_owner);
                // advance to the coming rising edge
                m_hs = e_en && async_rdy;
                if (m_owner < 0) begin
                    m_run = 0;
                    for (int k = 0; k < NR; k++) begin
                        m_j = (m_ptr + k) % NR;
                        if (m_owner < 0 && req_valid[m_j]) m_owner = m_j;
                    end
                end else begin
                    m_run = m_hs ? 0 : ((m_run < SM) ? m_run + 1 : SM);
                    if (m_run >= SM) m_err = 1;
                    if (m_hs && e_last) begin
                        m_ptr   = (m_owner + 1) % NR;
                        m_owner = -1;
                    end
                end
                if (stall_clr) begin
                    m_run = 0;
                    m_err = 0;
                end
            end
        end
    end

    // grant order and handshake count observers
    int  gq[$];
    int  hs_total = 0;
    bit  busy_d = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && busy && !busy_d) gq.push_back(int'(gnt_id));
            if (!rst && async_en && async_rdy) hs_total++;
            busy_d = rst ? 1'b0 : busy;
        end
    end

    // ---------------- requester engine ----------------
    int beats_left[NR], pkts[NR], plen[NR];
    int gap_pct = 0, drop_pct = 0, rdy_pct = 100, clr_pm = 0, fix_len = 0;
    bit new_pkts = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < NR; i++) if (pkts[i] > 0) p = 1;
        return p;
    endfunction

    task automatic step();
        logic [NR-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                beats_left[i]--;
                if (beats_left[i] == 0) pkts[i]--;
            end
            if (req_valid[i] && !acc[i]) begin
                if (beats_left[i] == plen[i] && !(busy && gnt_id == i) && $urandom_range(99) < drop_pct)
                    req_valid[i] = 1'b0;
            end else begin
                if (new_pkts && pkts[i] == 0 && $urandom_range(99) < 30) pkts[i] = 1;
                if (beats_left[i] == 0 && pkts[i] > 0) begin
                    plen[i]       = (fix_len > 0) ? fix_len : int'($urandom_range(1, 4));
                    beats_left[i] = plen[i];
                end
                if (beats_left[i] > 0 && $urandom_range(99) >= gap_pct) begin
                    req_valid[i]          = 1'b1;
                    req_data[i*DW +: DW]  = $urandom;
                    req_last[i]           = (beats_left[i] == 1);
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
        async_rdy = ($urandom_range(99) < rdy_pct);
        stall_clr = ($urandom_range(999) < clr_pm);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((pending() || busy || (req_valid != 0)) && n < bound) begin
            step();
            n++;
        end
        chk("drain_done", pending() || busy, 0);
    endtask

    // ---------------- directed + random scenarios ----------------
    int hs0;
    initial begin
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        async_rdy = 1'b0; stall_clr = 1'b0;
        for (int i = 0; i < NR; i++) begin beats_left[i] = 0; pkts[i] = 0; plen[i] = 0; end
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_en", async_en, 0);
        chk("init_err", stall_err, 0);
        rst = 1'b0;
        tick();

        // all four requesters, two-beat packets, requester 0 has two packets
        fix_len = 2;
        pkts[0] = 2; pkts[1] = 1; pkts[2] = 1; pkts[3] = 1;
        gq.delete();
        drain(200);
        chk("order_len", gq.size(), 5);
        if (gq.size() == 5) begin
            chk("order0", gq[0], 0); chk("order1", gq[1], 1); chk("order2", gq[2], 2);
            chk("order3", gq[3], 3); chk("order4", gq[4], 0);
        end
        tick();

        // requester 2 alone, three beats, slave always ready
        hs0 = hs_total;
        req_valid = 4'b0100; req_last = '0; async_rdy = 1'b1; stall_clr = 1'b0;
        req_data[2*DW +: DW] = 32'hA000_0000;
        #1 chk("s1_latency_en", async_en, 0);
        tick();
        chk("s1_busy", busy, 1);
        chk("s1_gnt", gnt_id, 2);
        chk("s1_data0", tx_data, 32'hA000_0000);
        tick();
        req_data[2*DW +: DW] = 32'hA000_0001;
        #1 chk("s1_data1", tx_data, 32'hA000_0001);
        tick();
        req_data[2*DW +: DW] = 32'hA000_0002; req_last[2] = 1'b1;
        #1 chk("s1_last", tx_last, 1);
        tick();
        req_valid = '0; req_last = '0;
        #1 chk("s1_done", busy, 0);
        chk("s1_hs", hs_total - hs0, 3);
        tick();

        // owner 3 with 0 and 3 pending: pointer wraps to 0
        fix_len = 1;
        pkts[0] = 1; pkts[3] = 1;
        gq.delete();
        drain(100);
        chk("wrap_len", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("wrap0", gq[0], 3);
            chk("wrap1", gq[1], 0);
        end
        tick();

        // requester 1, slave withholds ready 5 cycles mid-packet
        req_valid = 4'b0010; req_last = '0; async_rdy = 1'b0;
        req_data[1*DW +: DW] = 32'hB0B0_0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("s3_en", async_en, 1);
            chk("s3_data", tx_data, 32'hB0B0_0000);
            chk("s3_ready", req_ready[1], 0);
            chk("s3_gnt", gnt_id, 1);
            tick();
        end
        async_rdy = 1'b1;
        tick();
        req_data[1*DW +: DW] = 32'hB0B0_0001; req_last[1] = 1'b1;
        tick();
        req_valid = '0; req_last = '0;
        #1 chk("s3_done", busy, 0);
        tick();

        // watchdog: single-beat packet held by the slave
        req_valid = 4'b0010; req_last = 4'b0010; async_rdy = 1'b0;
        req_data[1*DW +: DW] = 32'hC0C0_0000;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("wd_err", stall_err, (k == 8));
        end
        tick(); tick();
        chk("wd_sticky", stall_err, 1);
        chk("wd_no_abort", async_en, 1);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("wd_clr", stall_err, 0);
        async_rdy = 1'b1;
        tick();
        req_valid = '0; req_last = '0;
        chk("wd_done", busy, 0);
        tick();

        // async reset on beat 2 of a 4-beat packet
        req_valid = 4'b0100; req_last = '0; async_rdy = 1'b1;
        req_data[2*DW +: DW] = 32'hD0D0_0000;
        tick();
        tick();
        req_data[2*DW +: DW] = 32'hD0D0_0001;
        #2 rst = 1'b1;
        #1;
        chk("ar_en", async_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_err", stall_err, 0);
        chk("ar_ready", req_ready, 0);
        req_valid = '0;
        tick(); tick();
        rst = 1'b0;
        pkts[1] = 1; pkts[3] = 1;
        gq.delete();
        drain(100);
        chk("ar_rearb_len", gq.size(), 2);
        if (gq.size() == 2) chk("ar_rearb", gq[0], 1);

        // randomized traffic with varying slave backpressure
        fix_len = 0; gap_pct = 20; drop_pct = 5; clr_pm = 5; new_pkts = 1;
        for (int c = 0; c < 15; c++) begin
            rdy_pct = (c % 3 == 0) ? 90 : ((c % 3 == 1) ? 50 : 10);
            repeat (200) step();
        end
        new_pkts = 0; gap_pct = 0; drop_pct = 0; clr_pm = 0; rdy_pct = 100;
        drain(2000);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
